decode_stage: RTL and testbench

Second pipeline stage: consumes the fetched instruction word and its PC from the fetch stage, decodes it into ALU/memory/branch controls, reads two source operands from the architectural register file, and registers everything into the DEC→EXE pipeline register. Owns the 32×32 register file, whose write port is driven by the writeback stage. Squashes wrong-path instructions for a fixed number of cycles after a taken branch.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/regfile.sv | 37 +++
 rtl/decode_stage.sv | 137 +++++++++++++
 tb/tb_decode_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU op encodings, instruction field
// positions and the DEC->EXE pipeline register layout.
package cpu_pkg;

  // Opcodes
  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h10;
  localparam logic [5:0] OP_SW   = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h18;
  localparam logic [5:0] OP_JMP  = 6'h19;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  // Instruction field positions
  localparam int OPC_LSB = 26;
  localparam int RD_LSB  = 21;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 11;

  // DEC->EXE pipeline register contents
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  alu_op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        mem_ren;
    logic        mem_wen;
    logic        is_beq;
    logic        is_jmp;
  } id_regs_t;

  // A bubble carries no instruction: invalid, all flags and data zero
  localparam id_regs_t ID_BUBBLE = '0;

  // Sign-extend the 16-bit immediate field
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 architectural register file, two combinational read ports and one
// write port. r0 is hardwired to zero; a write to the register being read in
// the same cycle is forwarded to the read port.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_reg [32];

  // Clear everything on reset (pending writes are dropped); r0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_reg[i] <= '0;
    end else if (wen && (waddr != 5'd0)) begin
      regs_reg[waddr] <= wdata;
    end
  end

  // Read ports with r0 forcing and write-through bypass
  always_comb begin
    rd1 = regs_reg[ra1];
    rd2 = regs_reg[ra2];
    if (ra1 == 5'd0)                         rd1 = '0;
    else if (wen && !rst && (waddr == ra1)) rd1 = wdata;
    if (ra2 == 5'd0)                         rd2 = '0;
    else if (wen && !rst && (waddr == ra2)) rd2 = wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes the fetched word into ALU/memory/branch controls,
// reads operands from the register file and registers the result into the
// DEC->EXE pipeline register. Wrong-path instructions are squashed for
// FLUSH_DEPTH cycles after a taken branch.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        flush,
  input  logic        wb_wen,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [2:0]  id_alu_op,
  output logic [31:0] id_rs1_data,
  output logic [31:0] id_rs2_data,
  output logic [31:0] id_imm,
  output logic        id_use_imm,
  output logic [4:0]  id_rd,
  output logic        id_reg_wen,
  output logic        id_mem_ren,
  output logic        id_mem_wen,
  output logic        id_is_beq,
  output logic        id_is_jmp,
  output logic        id_illegal
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

  logic [5:0]  opcode;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_rd;
  logic [31:0] rs2_rd;
  logic        legal;
  logic        squash;
  id_regs_t    dec;
  id_regs_t    id_next;
  logic        illegal_next;
  id_regs_t    id_reg;
  logic        illegal_reg;
  logic [2:0]  squash_cnt_reg;

  assign opcode   = if_instr[OPC_LSB +: 6];
  assign rs1_addr = if_instr[RS1_LSB +: 5];
  assign rs2_addr = if_instr[RS2_LSB +: 5];

  regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .ra1   (rs1_addr),
    .ra2   (rs2_addr),
    .rd1   (rs1_rd),
    .rd2   (rs2_rd),
    .wen   (wb_wen),
    .waddr (wb_addr),
    .wdata (wb_data)
  );

  // Combinational decode of the presented instruction word
  always_comb begin
    dec          = ID_BUBBLE;
    legal        = 1'b1;
    dec.valid    = 1'b1;
    dec.pc       = if_pc;
    dec.rs1_data = rs1_rd;
    dec.rs2_data = rs2_rd;
    dec.imm      = sext16(if_instr[15:0]);
    dec.rd       = if_instr[RD_LSB +: 5];
    dec.alu_op   = ALU_ADD;
    unique case (opcode)
      OP_NOP:  ;
      OP_ADD:  dec.reg_wen = 1'b1;
      OP_SUB:  begin dec.alu_op = ALU_SUB; dec.reg_wen = 1'b1; end
      OP_AND:  begin dec.alu_op = ALU_AND; dec.reg_wen = 1'b1; end
      OP_OR:   begin dec.alu_op = ALU_OR;  dec.reg_wen = 1'b1; end
      OP_XOR:  begin dec.alu_op = ALU_XOR; dec.reg_wen = 1'b1; end
      OP_ADDI: begin dec.use_imm = 1'b1; dec.reg_wen = 1'b1; end
      OP_LW:   begin dec.use_imm = 1'b1; dec.mem_ren = 1'b1; dec.reg_wen = 1'b1; end
      OP_SW:   begin dec.use_imm = 1'b1; dec.mem_wen = 1'b1; end
      OP_BEQ:  begin dec.alu_op = ALU_SUB; dec.is_beq = 1'b1; end
      OP_JMP:  dec.is_jmp = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Squash takes priority over illegal detection, so wrong-path junk never flags
  assign squash = flush || (squash_cnt_reg != 3'd0);

  // Select what the pipeline register loads this cycle
  always_comb begin
    id_next      = dec;
    illegal_next = 1'b0;
    if (squash) begin
      id_next = ID_BUBBLE;
    end else if (!legal) begin
      id_next      = ID_BUBBLE;
      illegal_next = 1'b1;
    end
  end

  // Pipeline register and squash counter; a flush always reloads the counter
  always_ff @(posedge clk) begin
    if (rst) begin
      id_reg         <= ID_BUBBLE;
      illegal_reg    <= 1'b0;
      squash_cnt_reg <= 3'd0;
    end else begin
      id_reg      <= id_next;
      illegal_reg <= illegal_next;
      if (flush)                      squash_cnt_reg <= FLUSH_RELOAD;
      else if (squash_cnt_reg != 3'd0) squash_cnt_reg <= squash_cnt_reg - 3'd1;
    end
  end

  assign id_valid    = id_reg.valid;
  assign id_pc       = id_reg.pc;
  assign id_alu_op   = id_reg.alu_op;
  assign id_rs1_data = id_reg.rs1_data;
  assign id_rs2_data = id_reg.rs2_data;
  assign id_imm      = id_reg.imm;
  assign id_use_imm  = id_reg.use_imm;
  assign id_rd       = id_reg.rd;
  assign id_reg_wen  = id_reg.reg_wen;
  assign id_mem_ren  = id_reg.mem_ren;
  assign id_mem_wen  = id_reg.mem_wen;
  assign id_is_beq   = id_reg.is_beq;
  assign id_is_jmp   = id_reg.is_jmp;
  assign id_illegal  = illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: a per-cycle reference model checked on every
// falling edge, plus hand-computed expectations for the directed vectors.
module tb_decode_stage;

  localparam int FD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_instr;
  logic        flush, wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_valid, id_use_imm, id_reg_wen, id_mem_ren, id_mem_wen;
  logic        id_is_beq, id_is_jmp, id_illegal;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [2:0]  id_alu_op;
  logic [4:0]  id_rd;

  int n_cmp = 0;
  int n_bad = 0;

  decode_stage #(.FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .flush(flush),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_alu_op(id_alu_op),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_rd(id_rd), .id_reg_wen(id_reg_wen),
    .id_mem_ren(id_mem_ren), .id_mem_wen(id_mem_wen), .id_is_beq(id_is_beq),
    .id_is_jmp(id_is_jmp), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Flags packed as {use_imm, reg_wen, mem_ren, mem_wen, is_beq, is_jmp}
  function automatic logic known_op(input logic [5:0] op, output logic [2:0] alu,
                                    output logic [5:0] fl);
    alu = 3'd0; fl = 6'b0;
    if (op == 6'h00) return 1'b1;
    if (op >= 6'h01 && op <= 6'h05) begin alu = 3'(op - 6'h01); fl = 6'b010000; return 1'b1; end
    if (op == 6'h08) begin fl = 6'b110000; return 1'b1; end
    if (op == 6'h10) begin fl = 6'b111000; return 1'b1; end
    if (op == 6'h11) begin fl = 6'b100100; return 1'b1; end
    if (op == 6'h18) begin alu = 3'd1; fl = 6'b000010; return 1'b1; end
    if (op == 6'h19) begin fl = 6'b000001; return 1'b1; end
    return 1'b0;
  endfunction

  logic [31:0] mregs [32];
  int          sq_left = 0;
  bit          exp_ready = 0;
  logic        e_valid, e_ill;
  logic [31:0] e_pc, e_rs1, e_rs2, e_imm;
  logic [2:0]  e_alu;
  logic [4:0]  e_rd;
  logic [5:0]  e_fl;

  // value a register holds once this cycle's writeback lands
  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_wen && wb_addr == a) return wb_data;
    return mregs[a];
  endfunction

  always @(posedge clk) begin
    logic squashed, ok;
    logic [2:0] alu;
    logic [5:0] fl;
    exp_ready = 1;
    e_valid = 0; e_ill = 0; e_pc = 0; e_rs1 = 0; e_rs2 = 0; e_imm = 0;
    e_alu = 0; e_rd = 0; e_fl = 0;
    if (rst) begin
      sq_left = 0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    end else begin
      squashed = flush || (sq_left > 0);
      if (flush) sq_left = FD - 1;
      else if (sq_left > 0) sq_left = sq_left - 1;
      if (!squashed) begin
        ok = known_op(if_instr[31:26], alu, fl);
        if (!ok) e_ill = 1;
        else begin
          e_valid = 1; e_pc = if_pc; e_alu = alu; e_fl = fl;
          e_rd  = if_instr[25:21];
          e_rs1 = mread(if_instr[20:16]);
          e_rs2 = mread(if_instr[15:11]);
          e_imm = 32'(signed'(if_instr[15:0]));
        end
      end
      if (wb_wen && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (exp_ready) begin
      chk("m_valid", 32'(id_valid), 32'(e_valid));
      chk("m_illegal", 32'(id_illegal), 32'(e_ill));
      chk("m_pc", id_pc, e_pc);
      chk("m_alu", 32'(id_alu_op), 32'(e_alu));
      chk("m_rs1", id_rs1_data, e_rs1);
      chk("m_rs2", id_rs2_data, e_rs2);
      chk("m_imm", id_imm, e_imm);
      chk("m_rd", 32'(id_rd), 32'(e_rd));
      chk("m_flags", 32'({id_use_imm, id_reg_wen, id_mem_ren, id_mem_wen, id_is_beq, id_is_jmp}),
          32'(e_fl));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] lo);
    return {op, rd, rs1, lo};
  endfunction

  function automatic logic [31:0] rt(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'h0};
  endfunction

  // Drive one cycle of inputs; on return the outputs reflect them
  task automatic step(input logic r, input logic [31:0] pc, input logic [31:0] in,
                      input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    rst = r; if_pc = pc; if_instr = in; flush = fl;
    wb_wen = we; wb_addr = wa; wb_data = wd;
    @(negedge clk);
  endtask

  logic [31:0] add312, nop;

  initial begin
    add312 = rt(6'h01, 5'd3, 5'd1, 5'd2);
    nop    = 32'h0;

    // Reset; a write attempted during reset must be dropped
    step(1, 32'h44, add312, 0, 1, 5'd5, 32'd99);
    step(1, 32'h44, add312, 0, 1, 5'd5, 32'd99);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_illegal", 32'(id_illegal), 32'd0);

    // Preload r1=5, r2=7, then ADD r3,r1,r2
    step(0, 32'h0F8, nop, 0, 1, 5'd1, 32'd5);
    step(0, 32'h0FC, rt(6'h01, 5'd0, 5'd5, 5'd0), 0, 1, 5'd2, 32'd7);
    chk("rst_r5_zero", id_rs1_data, 32'd0);
    chk("nop_valid", 32'(id_valid), 32'd1);
    step(0, 32'h100, add312, 0, 0, 5'd0, 32'd0);
    chk("add_valid", 32'(id_valid), 32'd1);
    chk("add_alu", 32'(id_alu_op), 32'd0);
    chk("add_rs1", id_rs1_data, 32'd5);
    chk("add_rs2", id_rs2_data, 32'd7);
    chk("add_rd", 32'(id_rd), 32'd3);
    chk("add_wen", 32'(id_reg_wen), 32'd1);

    // ADDI r4,r0,0xFFF0
    step(0, 32'h104, ins(6'h08, 5'd4, 5'd0, 16'hFFF0), 0, 0, 5'd0, 32'd0);
    chk("addi_imm", id_imm, 32'hFFFF_FFF0);
    chk("addi_use_imm", 32'(id_use_imm), 32'd1);
    chk("addi_rs1", id_rs1_data, 32'd0);

    // SUB r2,r1,r1 while WB writes r1: bypass
    step(0, 32'h108, rt(6'h02, 5'd2, 5'd1, 5'd1), 0, 1, 5'd1, 32'hDEAD_BEEF);
    chk("byp_rs1", id_rs1_data, 32'hDEAD_BEEF);
    chk("byp_rs2", id_rs2_data, 32'hDEAD_BEEF);
    chk("sub_alu", 32'(id_alu_op), 32'd1);

    // Write to r0 ignored, including the same-cycle read
    step(0, 32'h10C, rt(6'h01, 5'd6, 5'd0, 5'd0), 0, 1, 5'd0, 32'h1234);
    chk("r0_same", id_rs1_data, 32'd0);
    step(0, 32'h110, rt(6'h01, 5'd6, 5'd0, 5'd0), 0, 0, 5'd0, 32'd0);
    chk("r0_after", id_rs1_data, 32'd0);

    // Remaining opcodes (model-checked)
    step(0, 32'h114, ins(6'h10, 5'd7, 5'd1, 16'h8004), 0, 0, 5'd0, 32'd0);
    chk("lw_flags", 32'({id_mem_ren, id_reg_wen, id_use_imm}), 32'd7);
    step(0, 32'h118, ins(6'h11, 5'd0, 5'd1, {5'd2, 11'h010}), 0, 0, 5'd0, 32'd0);
    step(0, 32'h11C, rt(6'h18, 5'd0, 5'd1, 5'd2), 0, 0, 5'd0, 32'd0);
    step(0, 32'h120, ins(6'h19, 5'd0, 5'd0, 16'hFFFC), 0, 0, 5'd0, 32'd0);
    step(0, 32'h124, rt(6'h05, 5'd8, 5'd1, 5'd2), 0, 0, 5'd0, 32'd0);
    step(0, 32'h128, rt(6'h04, 5'd9, 5'd1, 5'd2), 0, 0, 5'd0, 32'd0);
    step(0, 32'h12C, rt(6'h03, 5'd9, 5'd1, 5'd2), 0, 0, 5'd0, 32'd0);

    // Single flush: two bubbles, then valid
    step(0, 32'h200, add312, 1, 0, 5'd0, 32'd0);
    chk("fl1_t1", 32'(id_valid), 32'd0);
    step(0, 32'h204, add312, 0, 0, 5'd0, 32'd0);
    chk("fl1_t2", 32'(id_valid), 32'd0);
    step(0, 32'h208, add312, 0, 0, 5'd0, 32'd0);
    chk("fl1_t3", 32'(id_valid), 32'd1);

    // Back-to-back flush extends the squash
    step(0, 32'h300, add312, 1, 0, 5'd0, 32'd0);
    step(0, 32'h304, add312, 1, 0, 5'd0, 32'd0);
    step(0, 32'h308, add312, 0, 0, 5'd0, 32'd0);
    chk("fl2_t3", 32'(id_valid), 32'd0);
    step(0, 32'h30C, add312, 0, 0, 5'd0, 32'd0);
    chk("fl2_t4", 32'(id_valid), 32'd1);

    // Illegal opcode: bubble plus a one-cycle pulse
    step(0, 32'h400, 32'hFC00_0000, 0, 0, 5'd0, 32'd0);
    chk("ill_pulse", 32'(id_illegal), 32'd1);
    chk("ill_valid", 32'(id_valid), 32'd0);
    step(0, 32'h404, add312, 0, 0, 5'd0, 32'd0);
    chk("ill_clear", 32'(id_illegal), 32'd0);

    // Illegal opcode while squashing: no pulse
    step(0, 32'h500, add312, 1, 0, 5'd0, 32'd0);
    step(0, 32'h504, 32'hFC00_0000, 0, 0, 5'd0, 32'd0);
    chk("ill_sq", 32'(id_illegal), 32'd0);
    step(0, 32'h508, add312, 0, 0, 5'd0, 32'd0);

    // Reset mid-squash clears registers and the remaining squash
    step(0, 32'h600, add312, 1, 1, 5'd2, 32'd77);
    step(1, 32'h604, add312, 0, 0, 5'd0, 32'd0);
    chk("rsq_valid", 32'(id_valid), 32'd0);
    step(0, 32'h608, add312, 0, 0, 5'd0, 32'd0);
    chk("rsq_first_valid", 32'(id_valid), 32'd1);
    chk("rsq_pc", id_pc, 32'h608);
    chk("rsq_rs1", id_rs1_data, 32'd0);
    chk("rsq_rs2", id_rs2_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
